seq_detect_ab_fsm: RTL and testbench



---
 rtl/seq_detect_ab_fsm.sv | 67 ++++++
 tb/tb_seq_detect_ab_fsm.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_ab_fsm.sv
// Moore detector for "a high, then b high on the next edge"; q holds while a&b stay high.
// Optional build macro SEQ_STATS_EN adds state_o and a saturating S2-residency counter hits_o.
module seq_detect_ab_fsm
`ifdef SEQ_STATS_EN
#(
  parameter int CNT_W = 8
)
`endif
(
  input  logic             clock,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  output logic             q
`ifdef SEQ_STATS_EN
  , output logic [1:0]       state_o
  , output logic [CNT_W-1:0] hits_o
`endif
);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10
  } state_t;

  state_t state_q, state_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S0;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = S0;
    case (state_q)
      S0:      state_d = a       ? S1 : S0;
      S1:      state_d = b       ? S2 : S0;
      S2:      state_d = (a & b) ? S2 : S0;
      default: state_d = S0;  // 2'b11 recovers to idle
    endcase
  end

  assign q = (state_q == S2);

`ifdef SEQ_STATS_EN
  logic [CNT_W-1:0] hits_q, hits_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hits_q <= '0;
    else       hits_q <= hits_d;
  end

  // Counts edges taken while already in S2; sticks at all-ones.
  always_comb begin
    hits_d = hits_q;
    if ((state_q == S2) && (hits_q != {CNT_W{1'b1}}))
      hits_d = hits_q + 1'b1;
  end

  assign state_o = state_q;
  assign hits_o  = hits_q;
`endif

endmodule

// File: tb/tb_seq_detect_ab_fsm.sv
// Self-checking bench for seq_detect_ab_fsm: directed vector table, async-reset corner,
// optional stats checks, and a randomized run against a sequence-parsing reference model.
module tb_seq_detect_ab_fsm;

  logic clock = 1'b0;
  logic reset;
  logic a, b;
  logic q;

  int errors = 0;
  int checks = 0;

`ifdef SEQ_STATS_EN
  logic [1:0] state_o, state2_o;
  logic [7:0] hits_o;
  logic [1:0] hits2_o;
  logic       q2;

  seq_detect_ab_fsm #(.CNT_W(8)) dut (
    .clock(clock), .reset(reset), .a(a), .b(b), .q(q),
    .state_o(state_o), .hits_o(hits_o)
  );
  seq_detect_ab_fsm #(.CNT_W(2)) dut_small (
    .clock(clock), .reset(reset), .a(a), .b(b), .q(q2),
    .state_o(state2_o), .hits_o(hits2_o)
  );
`else
  seq_detect_ab_fsm dut (
    .clock(clock), .reset(reset), .a(a), .b(b), .q(q)
  );
`endif

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic r, input logic ai, input logic bi);
    @(negedge clock);
    reset = r;
    a     = ai;
    b     = bi;
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic rst;
    logic a;
    logic b;
    logic q_exp;
  } vec_t;

  localparam int NVEC = 18;
  localparam int NRND = 400;

  vec_t vecs [NVEC];

  logic ra   [NRND];
  logic rb   [NRND];
  logic rq   [NRND];
  logic mq   [NRND];
`ifdef SEQ_STATS_EN
  logic [7:0] rhits [NRND];
`endif

  // Reference: parse the sample stream from reset into detection attempts.
  // An attempt begins at an a=1 sample; the next sample must carry b=1, after which
  // q stays high for every following a&b sample. The sample ending an attempt is
  // consumed by it, so the next attempt starts one sample later.
  task automatic build_model();
    int i;
    int j;
    for (int k = 0; k < NRND; k++) mq[k] = 1'b0;
    i = 0;
    while (i < NRND) begin
      if (ra[i] && (i + 1 < NRND)) begin
        if (rb[i+1]) begin
          mq[i+1] = 1'b1;
          j = i + 2;
          while (j < NRND && ra[j] && rb[j]) begin
            mq[j] = 1'b1;
            j++;
          end
          i = j + 1;
        end else begin
          i = i + 2;
        end
      end else begin
        i = i + 1;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    a     = 1'b0;
    b     = 1'b0;

    vecs = '{
      '{1'b1, 1'b1, 1'b1, 1'b0},  // held in reset despite a=b=1
      '{1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0},  // first edge out of reset: S0 -> S1 only
      '{1'b0, 1'b0, 1'b1, 1'b1},  // a ignored in S1
      '{1'b0, 1'b1, 1'b1, 1'b1},  // hold
      '{1'b0, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b0},  // release
      '{1'b0, 1'b1, 1'b0, 1'b0},  // basic detect: a
      '{1'b0, 1'b1, 1'b1, 1'b1},  //   then b
      '{1'b0, 1'b1, 1'b0, 1'b0},  // S2 with a=1,b=0 goes to S0, not S1
      '{1'b0, 1'b0, 1'b1, 1'b0},  //   so b alone does not re-detect
      '{1'b0, 1'b1, 1'b0, 1'b0},  // broken: a
      '{1'b0, 1'b1, 1'b0, 1'b0},  //   b missing -> S0
      '{1'b0, 1'b0, 1'b1, 1'b0},  //   b too late
      '{1'b0, 1'b1, 1'b1, 1'b0},  // a=b=1 in S0 -> S1 only
      '{1'b0, 1'b0, 1'b0, 1'b0}   // S1 without b -> S0
    };

    #1;
    check("reset_q_before_edge", q, 1'b0);

    for (int i = 0; i < NVEC; i++) begin
      step(vecs[i].rst, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_q", i), q, vecs[i].q_exp);
    end

    // Async reset while detected: q must drop with no clock edge.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("async_pre_q", q, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_q_no_edge", q, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("async_held_q", q, 1'b0);

`ifdef SEQ_STATS_EN
    check("stats_reset_hits", hits_o, 8'd0);
    check("stats_reset_state", state_o, 2'b00);
    step(1'b0, 1'b1, 1'b0);
    check("stats_state_s1", state_o, 2'b01);
    step(1'b0, 1'b1, 1'b1);
    check("stats_state_s2", state_o, 2'b10);
    check("stats_hits_entry", hits_o, 8'd0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b1);
    check("stats_hits_4", hits_o, 8'd4);
    for (int k = 0; k < 2; k++) step(1'b0, 1'b1, 1'b1);
    check("stats_hits_6", hits_o, 8'd6);
    check("stats_hits_sat", hits2_o, 2'd3);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("stats_hits_reset", hits_o, 8'd0);
    check("stats_hits2_reset", hits2_o, 2'd0);
    step(1'b1, 1'b0, 1'b0);
`endif

    // Randomized run from a fresh reset, biased toward high inputs so detections are common.
    step(1'b1, 1'b0, 1'b0);
    for (int t = 0; t < NRND; t++) begin
      ra[t] = ($urandom_range(0, 3) != 0);
      rb[t] = ($urandom_range(0, 3) != 0);
      step(1'b0, ra[t], rb[t]);
      rq[t] = q;
`ifdef SEQ_STATS_EN
      rhits[t] = hits_o;
`endif
    end
    build_model();
    begin
      int acc;
      acc = 0;
      for (int t = 0; t < NRND; t++) begin
        check($sformatf("rnd%0d_q", t), rq[t], mq[t]);
`ifdef SEQ_STATS_EN
        check($sformatf("rnd%0d_hits", t), rhits[t], (acc > 255) ? 255 : acc);
`endif
        if (mq[t]) acc++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
